// File: rtl/riscv_business.sv
// Multi-cycle RV32I core: FETCH -> EXECUTE -> (MEM) -> FETCH, stopping for good in HALTED.
// Instruction and data traffic share one generic request/busy bus.
module riscv_business #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        halt,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        ren,
  output logic        wen,
  output logic [3:0]  byte_en,
  input  logic        busy
);

  typedef enum logic [1:0] {FETCH, EXECUTE, MEM, HALTED} state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_t      state, state_next;
  logic [31:0] pc, pc_next, pc4, instr;
  logic [31:0] regs [32];
  logic        rd_we;
  logic [31:0] rd_val, target;

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] a, b, alu_b, alu_out, ea, lane, ld_val, st_data;
  logic [3:0]  mem_be;
  logic        alu_alt, taken, is_store, mem_misaligned, load_ok, store_ok;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign a      = regs[rs1];
  assign b      = regs[rs2];
  assign pc4    = pc + 32'd4;
  assign halt   = (state == HALTED);

  always_comb begin
    alu_b   = (opcode == OPC_OP) ? b : imm_i;
    alu_alt = instr[30] && (opcode == OPC_OP || f3 == 3'b101);
    case (f3)
      3'b000:  alu_out = alu_alt ? a - alu_b : a + alu_b;
      3'b001:  alu_out = a << alu_b[4:0];
      3'b010:  alu_out = {31'b0, $signed(a) < $signed(alu_b)};
      3'b011:  alu_out = {31'b0, a < alu_b};
      3'b100:  alu_out = a ^ alu_b;
      3'b101:  alu_out = alu_alt ? $unsigned($signed(a) >>> alu_b[4:0]) : a >> alu_b[4:0];
      3'b110:  alu_out = a | alu_b;
      default: alu_out = a & alu_b;
    endcase
    case (f3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = $signed(a) < $signed(b);
      3'b101:  taken = $signed(a) >= $signed(b);
      3'b110:  taken = a < b;
      3'b111:  taken = a >= b;
      default: taken = 1'b0;
    endcase
  end

  // Operands stay untouched between EXECUTE and MEM, so the access is decoded from instr/regs directly.
  always_comb begin
    is_store       = (opcode == OPC_STORE);
    ea             = a + (is_store ? imm_s : imm_i);
    mem_misaligned = (f3[1:0] == 2'b01 && ea[0]) || (f3[1:0] == 2'b10 && ea[1:0] != 2'b00);
    load_ok        = (f3[1:0] != 2'b11) && (f3 != 3'b110);
    store_ok       = !f3[2] && (f3[1:0] != 2'b11);
    case (f3[1:0])
      2'b00:   begin mem_be = 4'b0001 << ea[1:0];        st_data = {4{b[7:0]}};  end
      2'b01:   begin mem_be = 4'b0011 << {ea[1], 1'b0};  st_data = {2{b[15:0]}}; end
      default: begin mem_be = '1;                        st_data = b;            end
    endcase
    lane = rdata >> {ea[1:0], 3'b000};
    case (f3)
      3'b000:  ld_val = {{24{lane[7]}}, lane[7:0]};
      3'b100:  ld_val = {24'b0, lane[7:0]};
      3'b001:  ld_val = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ld_val = {16'b0, lane[15:0]};
      default: ld_val = lane;
    endcase
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    rd_we      = 1'b0;
    rd_val     = alu_out;
    target     = '0;
    ren        = 1'b0;
    wen        = 1'b0;
    addr       = '0;
    wdata      = '0;
    byte_en    = '0;
    case (state)
      FETCH: begin
        ren     = 1'b1;
        addr    = pc;
        byte_en = '1;
        if (!busy) state_next = EXECUTE;
      end
      EXECUTE: begin
        state_next = FETCH;
        pc_next    = pc4;
        case (opcode)
          OPC_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
          OPC_AUIPC: begin rd_we = 1'b1; rd_val = pc + imm_u; end
          OPC_JAL, OPC_JALR: begin
            target = (opcode == OPC_JAL) ? pc + imm_j : (a + imm_i) & ~32'd1;
            if (target[1] || (opcode == OPC_JALR && f3 != 3'b000)) state_next = HALTED;
            else begin
              rd_we   = 1'b1;
              rd_val  = pc4;
              pc_next = target;
            end
          end
          OPC_BRANCH: begin
            target = pc + imm_b;
            if (f3[2:1] == 2'b01 || (taken && target[1])) state_next = HALTED;
            else if (taken) pc_next = target;
          end
          OPC_LOAD, OPC_STORE: begin
            if (mem_misaligned || !(is_store ? store_ok : load_ok)) state_next = HALTED;
            else state_next = MEM;
            pc_next = pc;
          end
          OPC_OPIMM: begin
            if ((f3 == 3'b001 && f7 != 7'b0) ||
                (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000)) state_next = HALTED;
            else rd_we = 1'b1;
          end
          OPC_OP: begin
            if (f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) rd_we = 1'b1;
            else state_next = HALTED;
          end
          OPC_FENCE:  if (f3 != 3'b000) state_next = HALTED;
          OPC_SYSTEM: if (instr != 32'h0010_0073) state_next = HALTED;
          default:    state_next = HALTED;
        endcase
        if (state_next == HALTED) begin
          pc_next = pc;
          rd_we   = 1'b0;
        end
      end
      MEM: begin
        addr    = {ea[31:2], 2'b00};
        byte_en = mem_be;
        wen     = is_store;
        ren     = !is_store;
        wdata   = is_store ? st_data : '0;
        if (!busy) begin
          state_next = FETCH;
          pc_next    = pc4;
          rd_we      = !is_store;
          rd_val     = ld_val;
        end
      end
      default: ;
    endcase
    // Reset must silence the bus in the same cycle it is asserted, before any edge.
    if (!nRST) begin
      ren     = 1'b0;
      wen     = 1'b0;
      addr    = '0;
      wdata   = '0;
      byte_en = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= FETCH;
      pc    <= RESET_PC;
      instr <= '0;
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == FETCH && !busy) instr <= rdata;
      if (rd_we && rd != 5'd0) regs[rd] <= rd_val;
    end
  end

endmodule

// File: tb/tb_riscv_business.sv
// Directed bench for riscv_business: small hand-assembled programs run against a word RAM
// with programmable wait states; results are read back from RAM and the bus log.
module tb_riscv_business;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        halt, ren, wen, busy;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  byte_en;

  riscv_business #(.RESET_PC(32'h0000_0200)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt), .addr(addr), .wdata(wdata), .rdata(rdata),
    .ren(ren), .wen(wen), .byte_en(byte_en), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int          nvec = 0, nbad = 0;
  int          waits = 0, wcnt, ip, cyc;
  logic [31:0] img [2048];
  logic [31:0] mem [2048];
  int          nacc, nwr, nrd;
  logic [31:0] last_addr;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_wd [64];
  logic [3:0]  wr_be [64];
  logic [31:0] rd_addr [64];
  logic [3:0]  rd_be [64];
  int          stab_err, halt_req, both_err = 0;
  logic        hold;
  logic [69:0] snap;

  assign busy  = (ren || wen) && (wcnt < waits);
  assign rdata = mem[addr[12:2]];

  always @(posedge CLK) begin
    if (!nRST) begin
      mem <= img;
      wcnt <= 0; nacc <= 0; nwr <= 0; nrd <= 0; last_addr <= '0;
    end else if ((ren || wen) && busy) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
      if (ren || wen) begin
        nacc      <= nacc + 1;
        last_addr <= addr;
      end
      if (ren && nrd < 64) begin
        rd_addr[nrd] <= addr;
        rd_be[nrd]   <= byte_en;
        nrd          <= nrd + 1;
      end
      if (wen) begin
        for (int i = 0; i < 4; i++)
          if (byte_en[i]) mem[addr[12:2]][8*i +: 8] <= wdata[8*i +: 8];
        if (nwr < 64) begin
          wr_addr[nwr] <= addr;
          wr_wd[nwr]   <= wdata;
          wr_be[nwr]   <= byte_en;
          nwr          <= nwr + 1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (!nRST) begin
      hold = 1'b0; stab_err = 0; halt_req = 0;
    end else begin
      if (hold && snap != {ren, wen, addr, byte_en, wdata}) stab_err++;
      if (ren && wen) both_err++;
      if (halt && (ren || wen)) halt_req++;
      hold = (ren || wen) && busy;
      snap = {ren, wen, addr, byte_en, wdata};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3,
                                        input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_u(input int imm, input int rd, input logic [6:0] op);
    return {imm[19:0], rd[4:0], op};
  endfunction

  localparam logic [6:0] OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  task automatic clear_img();
    for (int i = 0; i < 2048; i++) img[i] = 32'hDEAD_BEEF;
    ip = 32'h200;
  endtask
  task automatic emit(input logic [31:0] w);
    img[ip >> 2] = w;
    ip += 4;
  endtask
  task automatic start(input int w);
    nRST  = 1'b0;
    waits = w;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask
  task automatic run_halt(input int budget, output int n);
    n = 0;
    while (!halt && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
  endtask

  task automatic prog_ldst();
    clear_img();
    emit(enc_u(1, 5, 7'b0110111));           // lui  x5,0x1
    emit(enc_u(32'h87654, 4, 7'b0110111));   // lui  x4,0x87654
    emit(enc_i(32'h321, 4, 0, 4, OP_IMM));   // addi x4,x4,0x321
    emit(enc_s(0, 4, 5, 2));                 // sw   x4,0(x5)
    emit(enc_i(32'hAA, 0, 0, 3, OP_IMM));    // addi x3,x0,0xAA
    emit(enc_s(1, 3, 5, 0));                 // sb   x3,1(x5)
    emit(enc_i(1, 5, 0, 6, OP_LOAD));        // lb   x6,1(x5)
    emit(enc_i(1, 5, 4, 7, OP_LOAD));        // lbu  x7,1(x5)
    emit(enc_s(4, 6, 5, 2));                 // sw   x6,4(x5)
    emit(enc_s(8, 7, 5, 2));                 // sw   x7,8(x5)
    emit(enc_i(2, 5, 1, 9, OP_LOAD));        // lh   x9,2(x5)
    emit(enc_s(12, 9, 5, 2));                // sw   x9,12(x5)
    emit(enc_i(1, 5, 1, 8, OP_LOAD));        // lh   x8,1(x5): misaligned
  endtask

  task automatic check_ldst(input string t, input int exp_cyc);
    check_eq({t, "_halt"}, {31'b0, halt}, 32'd1);
    check_eq({t, "_cycles"}, cyc, exp_cyc);
    check_eq({t, "_sw_word"}, mem[32'h400], 32'h8765_AA21);
    check_eq({t, "_lb"}, mem[32'h401], 32'hFFFF_FFAA);
    check_eq({t, "_lbu"}, mem[32'h402], 32'h0000_00AA);
    check_eq({t, "_lh"}, mem[32'h403], 32'hFFFF_8765);
    check_eq({t, "_nwr"}, nwr, 32'd5);
    check_eq({t, "_sw_be"}, {28'b0, wr_be[0]}, 32'hF);
    check_eq({t, "_sw_wd"}, wr_wd[0], 32'h8765_4321);
    check_eq({t, "_sb_addr"}, wr_addr[1], 32'h1000);
    check_eq({t, "_sb_be"}, {28'b0, wr_be[1]}, 32'b0010);
    check_eq({t, "_sb_wd"}, wr_wd[1], 32'hAAAA_AAAA);
    check_eq({t, "_lb_be"}, {28'b0, rd_be[7]}, 32'b0010);
    check_eq({t, "_lh_be"}, {28'b0, rd_be[13]}, 32'b1100);
    check_eq({t, "_lh_addr"}, rd_addr[13], 32'h1000);
    check_eq({t, "_no_lh_access"}, last_addr, 32'h230);
    check_eq({t, "_accesses"}, nacc, 32'd21);
  endtask

  logic [31:0] exp_alu [14];
  logic [31:0] exp_pc [11];
  logic        found;

  initial begin
    // Reset, first fetch, and exact halt timing of the minimal program
    clear_img();
    emit(enc_i(5, 0, 0, 1, OP_IMM));
    emit(enc_i(-7, 1, 0, 2, OP_IMM));
    emit(ECALL);
    waits = 0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_halt", {31'b0, halt}, 32'd0);
    check_eq("rst_ren", {31'b0, ren}, 32'd0);
    check_eq("rst_wen", {31'b0, wen}, 32'd0);
    check_eq("rst_addr", addr, 32'd0);
    check_eq("rst_wdata", wdata, 32'd0);
    check_eq("rst_byte_en", {28'b0, byte_en}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check_eq("fetch0_ren", {31'b0, ren}, 32'd1);
    check_eq("fetch0_addr", addr, 32'h200);
    check_eq("fetch0_be", {28'b0, byte_en}, 32'hF);
    run_halt(100, cyc);
    check_eq("ecall_halt", {31'b0, halt}, 32'd1);
    check_eq("ecall_cycle", cyc, 32'd6);
    repeat (5) @(posedge CLK);
    #1;
    check_eq("halted_no_req", halt_req, 32'd0);

    // ALU results stored to 0x100.. and checked in RAM
    clear_img();
    emit(enc_i(5, 0, 0, 1, OP_IMM));
    emit(enc_i(-7, 1, 0, 2, OP_IMM));
    emit(enc_i(-16, 0, 0, 3, OP_IMM));
    emit(enc_i(3, 0, 0, 4, OP_IMM));
    emit(enc_r(0, 3, 4, 0, 5) | 32'h4000_0000);   // sub  x5,x4,x3
    emit(enc_r(32'h20, 4, 3, 5, 6));              // sra  x6,x3,x4
    emit(enc_r(0, 4, 3, 5, 7));                   // srl  x7,x3,x4
    emit(enc_r(0, 4, 3, 2, 8));                   // slt  x8,x3,x4
    emit(enc_r(0, 4, 3, 3, 9));                   // sltu x9,x3,x4
    emit(enc_r(0, 4, 3, 4, 10));                  // xor  x10,x3,x4
    emit(enc_i(4, 4, 1, 11, OP_IMM));             // slli x11,x4,4
    emit(enc_u(1, 12, 7'b0010111));               // auipc x12,1 at 0x22C
    emit(enc_i(32'h402, 3, 5, 13, OP_IMM));       // srai x13,x3,2
    emit(enc_i(-1, 4, 3, 14, OP_IMM));            // sltiu x14,x4,-1
    for (int r = 1; r <= 14; r++) emit(enc_s(32'h100 + 4 * (r - 1), r, 0, 2));
    emit(ECALL);
    exp_alu = '{32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFF0, 32'd3, 32'd19, 32'hFFFF_FFFE,
                32'h1FFF_FFFE, 32'd1, 32'd0, 32'hFFFF_FFF3, 32'h30, 32'h0000_122C,
                32'hFFFF_FFFC, 32'd1};
    start(0);
    run_halt(300, cyc);
    check_eq("alu_halt", {31'b0, halt}, 32'd1);
    for (int r = 1; r <= 14; r++) check_eq($sformatf("alu_x%0d", r), mem[32'h40 + r - 1], exp_alu[r-1]);

    // Loads/stores with zero-wait RAM, then with 3 wait states per access
    prog_ldst();
    start(0);
    run_halt(300, cyc);
    check_ldst("ls0", 34);
    start(3);
    run_halt(300, cyc);
    check_ldst("ls3", 34 + 3 * 21);
    check_eq("ls3_stable", stab_err, 32'd0);

    // Control flow: taken BEQ, untaken BNE, JAL/JALR round trip, write to x0
    clear_img();
    emit(enc_i(3, 0, 0, 10, OP_IMM));        // 200 addi x10,x0,3
    emit(enc_b(8, 10, 10, 0));               // 204 beq  -> 20C
    emit(enc_i(99, 0, 0, 11, OP_IMM));       // 208 skipped
    emit(enc_b(8, 10, 10, 1));               // 20C bne  not taken
    emit(enc_j(8, 1));                       // 210 jal x1 -> 218
    emit(enc_j(8, 0));                       // 214 jal x0 -> 21C
    emit(enc_i(0, 1, 0, 0, 7'b1100111));     // 218 jalr x0,x1,0 -> 214
    emit(enc_i(1, 0, 0, 0, OP_IMM));         // 21C addi x0,x0,1
    emit(enc_s(32'h100, 1, 0, 2));           // 220 sw x1
    emit(enc_s(32'h104, 0, 0, 2));           // 224 sw x0
    emit(enc_s(32'h108, 11, 0, 2));          // 228 sw x11
    emit(ECALL);                             // 22C
    exp_pc = '{32'h200, 32'h204, 32'h20C, 32'h210, 32'h218, 32'h214, 32'h21C,
               32'h220, 32'h224, 32'h228, 32'h22C};
    start(0);
    run_halt(300, cyc);
    check_eq("cf_cycles", cyc, 32'd25);
    check_eq("cf_nfetch", nrd, 32'd11);
    for (int i = 0; i < 11; i++) check_eq($sformatf("cf_pc%0d", i), rd_addr[i], exp_pc[i]);
    check_eq("cf_x1_link", mem[32'h40], 32'h214);
    check_eq("cf_x0_zero", mem[32'h41], 32'h0);
    check_eq("cf_x11_skipped", mem[32'h42], 32'h0);

    // Illegal CSR instruction and misaligned jump target both stop the core
    clear_img();
    emit(enc_i(7, 0, 0, 1, OP_IMM));
    emit(enc_i(32'h300, 1, 1, 0, 7'b1110011));
    start(0);
    run_halt(100, cyc);
    check_eq("csr_halt", {31'b0, halt}, 32'd1);
    check_eq("csr_cycles", cyc, 32'd4);
    clear_img();
    emit(enc_j(6, 0));
    start(0);
    run_halt(100, cyc);
    check_eq("jmis_cycles", cyc, 32'd2);
    check_eq("jmis_accesses", nacc, 32'd1);

    // Reset asserted during a stalled data access
    prog_ldst();
    start(3);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge CLK);
      if ((ren || wen) && busy && addr == 32'h1000) found = 1'b1;
    end
    check_eq("mid_mem_found", {31'b0, found}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    check_eq("abort_ren", {31'b0, ren}, 32'd0);
    check_eq("abort_wen", {31'b0, wen}, 32'd0);
    check_eq("abort_addr", addr, 32'd0);
    check_eq("abort_be", {28'b0, byte_en}, 32'd0);
    check_eq("abort_wdata", wdata, 32'd0);
    check_eq("abort_halt", {31'b0, halt}, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check_eq("restart_addr", addr, 32'h200);
    check_eq("restart_ren", {31'b0, ren}, 32'd1);
    run_halt(300, cyc);
    check_ldst("rst3", 34 + 3 * 21);
    check_eq("never_ren_wen", both_err, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/riscv_business.md
# riscv_business

Minimal multi-cycle RV32I processor core acting as the single master on a generic bus shared by instruction and data traffic. It fetches, decodes and executes one instruction at a time, and stops permanently with `halt` on ECALL, an illegal instruction or a misaligned access. It sits between the board-level top and a word-wide RAM slave; every bus read result is visible on `rdata` for debug displays.

## Interface
- RESET_PC, 32'h0000_0200, fetch address after reset.
- CLK  in  1  system clock, all state on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- halt  out  1  sticky stop indicator; 1 = core stopped.
- gen_bus_if.addr  out  32  byte address of current request.
- gen_bus_if.wdata  out  32  store data, replicated into the enabled byte lanes.
- gen_bus_if.rdata  in  32  read data, valid in the cycle busy=0 with ren=1.
- gen_bus_if.ren  out  1  read request.
- gen_bus_if.wen  out  1  write request.
- gen_bus_if.byte_en  out  4  lane enables; bit i = bits [8i+7:8i], little-endian.
- gen_bus_if.busy  in  1  slave stall; request completes in the cycle it is 0.

## Operation
- States: FETCH, EXECUTE, MEM, HALTED.
- FETCH: ren=1, addr=pc, byte_en=4'hF. On busy=0, latch rdata as instr and go to EXECUTE.
- EXECUTE: decode and execute instr.
  - ALU/LUI/AUIPC/JAL/JALR/branch: write rd, update pc, go to FETCH.
  - Load/store: compute effective address, go to MEM.
  - ECALL (32'h0000_0073), unsupported opcode or funct: go to HALTED.
- Supported set: full RV32I integer set. FENCE and EBREAK behave as NOP. CSR instructions are illegal.
- MEM: exactly one of ren/wen is 1; addr = effective address with bits [1:0] cleared.
  - LW/SW: byte_en=4'hF.
  - LH/LHU/SH: byte_en=4'b0011 << addr[1]*2.
  - LB/LBU/SB: byte_en=4'b0001 << addr[1:0].
  - Loads extract the lane and sign- or zero-extend, writing rd when busy=0.
  - Stores replicate the byte/half across wdata.
  - pc += 4, then go to FETCH.
- Misaligned accesses go to HALTED with no bus access:
  - halfword with addr[0]=1,
  - word with addr[1:0]≠0,
  - taken jump/branch target with bit1=1.
- JALR target is (rs1+imm) & ~1. JAL/JALR write pc+4 to rd.
- x0 reads 0 and writes to it are discarded. Register file is 32x32, 2 read ports, 1 write port.
- Shifts use rs2[4:0] or shamt. SLT/SLTU use signed/unsigned compare. Arithmetic wraps mod 2^32.
- HALTED: halt=1, ren=wen=0, pc frozen. Only nRST exits this state.

## Timing
- Reset (async assert) forces:
  - state=FETCH, pc=RESET_PC, halt=0,
  - ren=0, wen=0, addr=0, wdata=0, byte_en=0,
  - all registers 0.
- First cycle after nRST deasserts: ren=1, addr=RESET_PC.
- Request signals are combinational from state and are held stable until the completing cycle (busy=0).
- ren and wen are never both 1. No request is issued in EXECUTE or HALTED.
- With a zero-wait slave (busy=0 the same cycle):
  - ALU, jump and branch instructions take 2 cycles,
  - loads and stores take 3 cycles.
  - Each busy=1 cycle adds one cycle.
- Register writes and the pc update occur on the rising edge that leaves EXECUTE, or MEM for loads.
- halt rises on the edge entering HALTED.
- nRST asserted mid-transaction aborts it immediately. The slave must tolerate a dropped request.

## Test plan
- Reset and fetch:
  - Stimulus: hold nRST=0, release.
  - Required: halt=0, ren=0 during reset; next cycle ren=1, addr=0x200, byte_en=F.
- ALU and halt:
  - Program: `addi x1,x0,5; addi x2,x1,-7; ecall` with zero-wait RAM.
  - Required: x1=5, x2=0xFFFF_FFFE; halt=1 at cycle 6 after reset release, then no further bus requests.
- Stores and loads:
  - Program: store 0x8765_4321 at 0x1000, then `sb x3,1(x?)` with x3=0xAA, then LB, LBU, LH from 0x1001.
  - Required: SB issues byte_en=4'b0010, wdata=0xAAAA_AAAA.
  - Required: LB→0xFFFF_FFAA, LBU→0x0000_00AA.
  - Required: LH at 0x1001 halts with no bus request.
- Control flow:
  - Program: BEQ taken, BNE not taken, JAL x1,+8, JALR x0,x1,0.
  - Required: pc sequence matches; x1 = JAL address + 4; x0 stays 0 after `addi x0,x0,1`.
- Bus wait states:
  - Stimulus: busy=1 for 3 cycles on every request.
  - Required: addr, ren and byte_en are stable throughout; the same results as the zero-wait run; each access stretches by 3 cycles.
- Reset mid-operation:
  - Stimulus: assert nRST while in MEM with busy=1.
  - Required: outputs drop to reset values in the same cycle; the core restarts at 0x200.
